// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 keyboard receiver with make/break decoding for A, D and Space
// Produces held levels and single-cycle press pulses for the game control logic.
module ps2_key_tracker #(
    parameter int          TIMEOUT   = 50000,
    parameter logic [7:0]  KEY_A     = 8'h1C,
    parameter logic [7:0]  KEY_D     = 8'h23,
    parameter logic [7:0]  KEY_SPACE = 8'h29
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error,
    output logic       keyboardAPressed,
    output logic       keyboardDPressed,
    output logic       keyboardSpacePressed,
    output logic       aPress,
    output logic       dPress,
    output logic       spacePress
);

    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } dec_state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic [10:0]   frame;
    logic          frame_ok;
    logic [IW-1:0] idle_cnt;
    dec_state_t    state;

    assign fall  = clk_prev & ~clk_sync[1];
    // shift[0] holds the start bit, shift[9] the parity bit; the stop bit is the live sample
    assign frame    = {dat_sync[1], shift};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync    <= 2'b11;
            dat_sync    <= 2'b11;
            clk_prev    <= 1'b1;
            bit_cnt     <= 4'd0;
            shift       <= 10'd0;
            idle_cnt    <= '0;
            scan_code   <= 8'h00;
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[0], ps2_clk};
            dat_sync    <= {dat_sync[0], ps2_dat};
            clk_prev    <= clk_sync[1];
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        scan_code  <= frame[8:1];
                        scan_valid <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end else begin
                    shift   <= {dat_sync[1], shift[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (idle_cnt != IW'(TIMEOUT)) begin
                idle_cnt <= idle_cnt + IW'(1);
                if (idle_cnt == IW'(TIMEOUT - 1) && bit_cnt != 4'd0) begin
                    bit_cnt     <= 4'd0;
                    frame_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            keyboardAPressed     <= 1'b0;
            keyboardDPressed     <= 1'b0;
            keyboardSpacePressed <= 1'b0;
            aPress               <= 1'b0;
            dPress               <= 1'b0;
            spacePress           <= 1'b0;
        end else begin
            aPress     <= 1'b0;
            dPress     <= 1'b0;
            spacePress <= 1'b0;
            if (frame_error) begin
                state <= IDLE;
            end else if (scan_valid) begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                        if (scan_code == 8'hF0) begin
                            state <= BREAK;
                        end else if (scan_code == 8'hE0) begin
                            state <= EXT;
                        end else if (scan_code == KEY_A) begin
                            keyboardAPressed <= 1'b1;
                            aPress           <= ~keyboardAPressed;
                        end else if (scan_code == KEY_D) begin
                            keyboardDPressed <= 1'b1;
                            dPress           <= ~keyboardDPressed;
                        end else if (scan_code == KEY_SPACE) begin
                            keyboardSpacePressed <= 1'b1;
                            spacePress           <= ~keyboardSpacePressed;
                        end
                    end
                    BREAK: begin
                        if (scan_code == KEY_A)     keyboardAPressed     <= 1'b0;
                        if (scan_code == KEY_D)     keyboardDPressed     <= 1'b0;
                        if (scan_code == KEY_SPACE) keyboardSpacePressed <= 1'b0;
                        state <= IDLE;
                    end
                    // Extended (E0-prefixed) codes are consumed without touching key state
                    EXT:       state <= (scan_code == 8'hF0) ? EXT_BREAK : IDLE;
                    EXT_BREAK: state <= IDLE;
                    default:   state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - table-driven bench for ps2_key_tracker
module tb_ps2_key_tracker;

    localparam int TO = 500;
    localparam int H  = 20;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, frame_error;
    logic       keyboardAPressed, keyboardDPressed, keyboardSpacePressed;
    logic       aPress, dPress, spacePress;

    ps2_key_tracker #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .scan_code(scan_code), .scan_valid(scan_valid), .frame_error(frame_error),
        .keyboardAPressed(keyboardAPressed), .keyboardDPressed(keyboardDPressed),
        .keyboardSpacePressed(keyboardSpacePressed),
        .aPress(aPress), .dPress(dPress), .spacePress(spacePress)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] code;
        logic       bad;
        logic       a, d, s;
        logic [1:0] ap, dp, sp, sv, fe;
    } vec_t;

    int checks = 0, passed = 0;
    int sv_cnt = 0, fe_cnt = 0, ap_cnt = 0, dp_cnt = 0, sp_cnt = 0;
    time sv_time = 0, ap_time = 0, a_chg_time = 0, fe_time = 0, fall_time = 0;
    logic a_prev = 1'b0;

    always @(negedge clock) begin
        if (scan_valid)  begin sv_cnt++; sv_time = $time; end
        if (frame_error) begin fe_cnt++; fe_time = $time; end
        if (aPress)      begin ap_cnt++; ap_time = $time; end
        if (dPress)      dp_cnt++;
        if (spacePress)  sp_cnt++;
        if (keyboardAPressed != a_prev) a_chg_time = $time;
        a_prev = keyboardAPressed;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic send_bits(input logic [7:0] code, input logic bad, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps2_dat = f[i];
            repeat (H) @(negedge clock);
            ps2_clk = 1'b0;
            fall_time = $time;
            repeat (H) @(negedge clock);
            ps2_clk = 1'b1;
        end
        repeat (2 * H) @(negedge clock);
    endtask

    function automatic vec_t mk(input logic [7:0] c, input logic b, input logic a, input logic d,
                                input logic s, input logic [1:0] ap, input logic [1:0] dp,
                                input logic [1:0] sp, input logic [1:0] sv, input logic [1:0] fe);
        vec_t v;
        v.code = c; v.bad = b; v.a = a; v.d = d; v.s = s;
        v.ap = ap; v.dp = dp; v.sp = sp; v.sv = sv; v.fe = fe;
        return v;
    endfunction

    vec_t vecs [18];
    int b_sv, b_fe, b_ap, b_dp, b_sp;
    logic [7:0] exp_code;

    initial begin
        vecs[0]  = mk(8'h1C, 0, 1, 0, 0, 1, 0, 0, 1, 0);
        vecs[1]  = mk(8'h1C, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(8'h1C, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[3]  = mk(8'h1C, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[4]  = mk(8'hF0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[5]  = mk(8'h1C, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[6]  = mk(8'h23, 0, 0, 1, 0, 0, 1, 0, 1, 0);
        vecs[7]  = mk(8'h1C, 0, 1, 1, 0, 1, 0, 0, 1, 0);
        vecs[8]  = mk(8'hF0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        vecs[9]  = mk(8'h23, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[10] = mk(8'hF0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[11] = mk(8'h1C, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[12] = mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[13] = mk(8'h1C, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[14] = mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[15] = mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[16] = mk(8'h1C, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[17] = mk(8'h1C, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        repeat (4) @(negedge clock);
        chk("reset_outputs",
            int'({scan_code, scan_valid, frame_error, keyboardAPressed, keyboardDPressed,
                  keyboardSpacePressed, aPress, dPress, spacePress}), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        exp_code = 8'h00;
        for (int i = 0; i < 18; i++) begin
            b_sv = sv_cnt; b_fe = fe_cnt; b_ap = ap_cnt; b_dp = dp_cnt; b_sp = sp_cnt;
            send_bits(vecs[i].code, vecs[i].bad, 11);
            if (!vecs[i].bad) exp_code = vecs[i].code;
            chk($sformatf("v%0d_scan_valid", i), sv_cnt - b_sv, int'(vecs[i].sv));
            chk($sformatf("v%0d_frame_error", i), fe_cnt - b_fe, int'(vecs[i].fe));
            chk($sformatf("v%0d_scan_code", i), int'(scan_code), int'(exp_code));
            chk($sformatf("v%0d_a_level", i), int'(keyboardAPressed), int'(vecs[i].a));
            chk($sformatf("v%0d_d_level", i), int'(keyboardDPressed), int'(vecs[i].d));
            chk($sformatf("v%0d_s_level", i), int'(keyboardSpacePressed), int'(vecs[i].s));
            chk($sformatf("v%0d_a_press", i), ap_cnt - b_ap, int'(vecs[i].ap));
            chk($sformatf("v%0d_d_press", i), dp_cnt - b_dp, int'(vecs[i].dp));
            chk($sformatf("v%0d_s_press", i), sp_cnt - b_sp, int'(vecs[i].sp));
            if (i == 0) begin
                chk("a_press_latency", int'((ap_time - sv_time) / 10), 1);
                chk("a_set_latency", int'((a_chg_time - sv_time) / 10), 1);
            end
            if (i == 5) chk("a_clear_latency", int'((a_chg_time - sv_time) / 10), 1);
        end

        // partial frame then stall past the timeout
        b_fe = fe_cnt; b_sv = sv_cnt;
        send_bits(8'h29, 0, 5);
        repeat (TO + 100) @(negedge clock);
        chk("timeout_error_count", fe_cnt - b_fe, 1);
        chk("timeout_no_valid", sv_cnt - b_sv, 0);
        chk("timeout_latency_ok",
            int'((fe_time - fall_time) / 10 >= TO && (fe_time - fall_time) / 10 <= TO + 5), 1);

        b_sp = sp_cnt; b_fe = fe_cnt;
        send_bits(8'h29, 0, 11);
        chk("space_after_timeout_press", sp_cnt - b_sp, 1);
        chk("space_after_timeout_level", int'(keyboardSpacePressed), 1);
        chk("space_after_timeout_no_err", fe_cnt - b_fe, 0);

        // reset in the middle of a frame while Space is held
        send_bits(8'h29, 0, 5);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            int'({scan_code, scan_valid, frame_error, keyboardAPressed, keyboardDPressed,
                  keyboardSpacePressed, aPress, dPress, spacePress}), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        b_sv = sv_cnt; b_sp = sp_cnt; b_fe = fe_cnt;
        repeat (50) @(negedge clock);
        chk("post_reset_quiet_valid", sv_cnt - b_sv, 0);
        chk("post_reset_quiet_press", sp_cnt - b_sp, 0);
        send_bits(8'h29, 0, 11);
        chk("post_reset_space_press", sp_cnt - b_sp, 1);
        chk("post_reset_space_level", int'(keyboardSpacePressed), 1);
        chk("post_reset_no_err", fe_cnt - b_fe, 0);
        chk("post_reset_scan_code", int'(scan_code), 8'h29);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #50ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
